// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: strobes one column low at a time, debounces whole-keypad
// frames and reports single-key presses, holds and multi-key presses.
module keypad_scan #(
    parameter int SETTLE    = 2,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_multi
);
    localparam int DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(DEB_SCANS + 1);

    typedef enum logic [1:0] {R_NONE, R_KEY, R_MULTI} raw_t;
    typedef enum logic [1:0] {IDLE, HELD, MULTI} state_t;

    logic [3:0]       row_s1, row_s2;
    logic [1:0]       col_idx;
    logic [DW-1:0]    dwell;
    logic             strobe;
    logic [1:0]       samp_vld;
    logic [1:0][1:0]  samp_col;
    logic [1:0][3:0]  col_bits;
    logic [3:0]       cur_bits;
    logic             frame;

    raw_t             raw_kind, prev_kind;
    logic [3:0]       raw_code, prev_code;
    logic [CW-1:0]    stable_cnt;
    logic             same, accept;

    state_t           state, state_n;
    logic [3:0]       code_n;
    logic             valid_n;

    function automatic logic [3:0] key_lut(input int r, input int c);
        if (r == 3)
            return (c == 0) ? 4'hA : (c == 1) ? 4'h0 : 4'hB;
        return 4'(r * 3 + c + 1);
    endfunction

    always_comb begin
        case (col_idx)
            2'd0:    key_col = 3'b110;
            2'd1:    key_col = 3'b101;
            default: key_col = 3'b011;
        endcase
    end

    assign strobe = (dwell == DW'(SETTLE - 1));

    // The synchronizer delays rows by two clocks, so the sample strobe and
    // its column index are delayed by the same amount before storing.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1   <= '1;
            row_s2   <= '1;
            col_idx  <= '0;
            dwell    <= '0;
            samp_vld <= '0;
            samp_col <= '0;
            col_bits <= '0;
        end else begin
            row_s1   <= key_row;
            row_s2   <= row_s1;
            samp_vld <= {samp_vld[0], strobe};
            samp_col <= {samp_col[0], col_idx};
            if (strobe) begin
                dwell   <= '0;
                col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            end else begin
                dwell   <= dwell + DW'(1);
            end
            if (samp_vld[1] && samp_col[1] != 2'd2)
                col_bits[samp_col[1][0]] <= ~row_s2;
        end
    end

    assign cur_bits = ~row_s2;
    assign frame    = samp_vld[1] && (samp_col[1] == 2'd2);

    always_comb begin
        logic [3:0]  cnt;
        logic [11:0] all_bits;
        all_bits = {cur_bits, col_bits[1], col_bits[0]};
        cnt      = '0;
        raw_code = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (all_bits[c*4 + r]) begin
                    cnt      = cnt + 4'd1;
                    raw_code = key_lut(r, c);
                end
            end
        end
        if (cnt == 4'd0)      raw_kind = R_NONE;
        else if (cnt == 4'd1) raw_kind = R_KEY;
        else                  raw_kind = R_MULTI;
    end

    assign same   = (raw_kind == prev_kind) && (raw_kind != R_KEY || raw_code == prev_code);
    assign accept = frame && same && (stable_cnt == CW'(DEB_SCANS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind  <= R_NONE;
            prev_code  <= '0;
            stable_cnt <= '0;
        end else if (frame) begin
            if (same) begin
                if (stable_cnt != CW'(DEB_SCANS))
                    stable_cnt <= stable_cnt + CW'(1);
            end else begin
                prev_kind  <= raw_kind;
                prev_code  <= raw_code;
                stable_cnt <= CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    // Only debounced frames move the FSM; a new key while held is ignored.
    always_comb begin
        state_n = state;
        code_n  = key_code;
        valid_n = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (raw_kind == R_KEY) begin
                        state_n = HELD;
                        code_n  = raw_code;
                        valid_n = 1'b1;
                    end else if (raw_kind == R_MULTI) begin
                        state_n = MULTI;
                    end
                end
                HELD: begin
                    if (raw_kind == R_NONE)       state_n = IDLE;
                    else if (raw_kind == R_MULTI) state_n = MULTI;
                end
                MULTI: begin
                    if (raw_kind == R_NONE) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign key_held  = (state == HELD);
    assign key_multi = (state == MULTI);
endmodule
